// File: rtl/alu_result_packer.sv
// alu_result_packer: captures a 2*BYTE_WIDTH ALU result and serialises it
// LSB first onto a byte-wide TX FIFO write port, honouring FIFO_FULL.
// Ports: CLK, RST (async active-low), ALU_OUT/OUT_VALID (result in),
//        FIFO_FULL (back-pressure), WR_DATA/WR_INC (FIFO write),
//        READY (can accept at coming edge), OVERRUN (dropped-result pulse).
module alu_result_packer #(
    parameter int ALU_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  FIFO_FULL,
    output logic [BYTE_WIDTH-1:0] WR_DATA,
    output logic                  WR_INC,
    output logic                  READY,
    output logic                  OVERRUN
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_LSB = 2'd1,
        SEND_MSB = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ALU_WIDTH-1:0]   hold_q, hold_d;
    logic                   ovr_q, ovr_d;
    logic                   accept;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        WR_DATA = '0;
        WR_INC  = 1'b0;
        READY   = 1'b0;
        unique case (state_q)
            IDLE: begin
                READY = 1'b1;
            end
            SEND_LSB: begin
                WR_DATA = hold_q[BYTE_WIDTH-1:0];
                WR_INC  = !FIFO_FULL;
                if (!FIFO_FULL) begin
                    state_d = SEND_MSB;
                end
            end
            SEND_MSB: begin
                WR_DATA = hold_q[ALU_WIDTH-1:BYTE_WIDTH];
                WR_INC  = !FIFO_FULL;
                READY   = !FIFO_FULL;
                if (!FIFO_FULL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new result overrides the IDLE/SEND_MSB exit and starts a
        // fresh transfer; the MSB of the previous one is written this edge.
        accept = OUT_VALID && READY;
        if (accept) begin
            hold_d  = ALU_OUT;
            state_d = SEND_LSB;
        end
        ovr_d = OUT_VALID && !READY;
    end

    assign OVERRUN = ovr_q;

endmodule
